ship_motion: RTL and testbench

SHIP_MOTION -- requirements
Module: ship_motion

---
 rtl/ship_pkg.sv | 23 ++
 rtl/tilt_speed.sv | 34 +++
 rtl/ship_motion.sv | 198 +++++++++++++++++++
 tb/tb_ship_motion.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ship_pkg.sv
// Shared definitions for the ship motion block: FSM states, screen geometry
// defaults and the tilt-to-speed threshold multipliers.
package ship_pkg;

    localparam int SCREEN_CORDW = 16;
    localparam int H_RES_DEF    = 640;
    localparam int V_RES_DEF    = 480;
    localparam int SAMPLE_W     = 16;
    localparam int BUF_DEPTH    = 4;

    // Speed bands: |avg| < DEADZONE -> 0, < DEADZONE*SPEED2_MULT -> 1,
    // < DEADZONE*SPEED3_MULT -> 2, otherwise 3 px/frame.
    localparam int DEADZONE_DEF = 128;
    localparam int SPEED2_MULT  = 4;
    localparam int SPEED3_MULT  = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILTER = 2'd1,
        ST_SPEED  = 2'd2
    } state_t;

endpackage

// File: rtl/tilt_speed.sv
// Combinational map from a signed tilt average to a signed speed of
// 0..3 px/frame, keeping the sign of the tilt.
module tilt_speed
    import ship_pkg::*;
#(
    parameter int DEADZONE = DEADZONE_DEF
) (
    input  logic signed [SAMPLE_W-1:0] avg,
    output logic signed [2:0]          speed
);

    localparam logic [SAMPLE_W:0] TH1 = (SAMPLE_W+1)'(DEADZONE);
    localparam logic [SAMPLE_W:0] TH2 = (SAMPLE_W+1)'(DEADZONE * SPEED2_MULT);
    localparam logic [SAMPLE_W:0] TH3 = (SAMPLE_W+1)'(DEADZONE * SPEED3_MULT);

    logic [SAMPLE_W:0] mag;
    logic [2:0]        level;

    // Magnitude is one bit wider so the most negative sample cannot overflow.
    always_comb begin
        mag   = avg[SAMPLE_W-1] ? (~{avg[SAMPLE_W-1], avg} + (SAMPLE_W+1)'(1))
                                : {1'b0, avg};
        level = 3'd3;
        if (mag < TH1) begin
            level = 3'd0;
        end else if (mag < TH2) begin
            level = 3'd1;
        end else if (mag < TH3) begin
            level = 3'd2;
        end
        speed = avg[SAMPLE_W-1] ? (~level + 3'd1) : level;
    end

endmodule

// File: rtl/ship_motion.sv
// Ship sprite motion from accelerometer tilt: samples are buffered, filtered,
// mapped to a per-axis speed and applied to the sprite position once per frame.
// Build option: define SHIP_SMOOTH_EN to average the last four samples per
// axis; without it the newest sample is used directly (same FSM timing).
module ship_motion #(
    parameter int H_RES        = ship_pkg::H_RES_DEF,
    parameter int V_RES        = ship_pkg::V_RES_DEF,
    parameter int SCREEN_CORDW = ship_pkg::SCREEN_CORDW,
    parameter int SHIP_W       = 34,
    parameter int SHIP_H       = 36,
    parameter int X_INIT       = 300,
    parameter int Y_INIT       = 240,
    parameter int DEADZONE     = ship_pkg::DEADZONE_DEF
) (
    input  logic                                  clk_pix,
    input  logic                                  rst,
    input  logic signed [ship_pkg::SAMPLE_W-1:0]  data_x,
    input  logic signed [ship_pkg::SAMPLE_W-1:0]  data_y,
    input  logic                                  data_update,
    input  logic                                  frame,
    input  logic                                  hold,
    output logic [SCREEN_CORDW-1:0]               ship_x,
    output logic [SCREEN_CORDW-1:0]               ship_y,
    output logic                                  moving,
    output logic                                  sample_ovf
);
    import ship_pkg::*;

    localparam int PW = SCREEN_CORDW + 2;
    localparam logic signed [PW-1:0] X_MAX = PW'(H_RES - SHIP_W);
    localparam logic signed [PW-1:0] Y_MAX = PW'(V_RES - SHIP_H);

    state_t state_reg, state_next;

    logic signed [SAMPLE_W-1:0] buf_x_reg [BUF_DEPTH];
    logic signed [SAMPLE_W-1:0] buf_y_reg [BUF_DEPTH];
    logic                       pend_valid_reg, ovf_reg;
    logic signed [SAMPLE_W-1:0] pend_x_reg, pend_y_reg;
    logic signed [SAMPLE_W-1:0] cap_x, cap_y;
    logic                       accept;

    // Index 0 is the x axis, index 1 the y axis.
    logic signed [SAMPLE_W-1:0] filt [2];
    logic signed [SAMPLE_W-1:0] avg_reg [2];
    logic signed [2:0]          spd [2];

    logic                       vel_load_reg;
    logic signed [2:0]          vel_x_reg, vel_y_reg, vel_x_next, vel_y_next;
    logic                       moving_reg;
    logic [SCREEN_CORDW-1:0]    ship_x_reg, ship_y_reg, ship_x_next, ship_y_next;
    logic signed [PW-1:0]       x_sum, y_sum;

    // A pending sample is always older than one arriving now, so it wins.
    assign accept = (state_reg == ST_IDLE) && (data_update || pend_valid_reg);
    assign cap_x  = pend_valid_reg ? pend_x_reg : data_x;
    assign cap_y  = pend_valid_reg ? pend_y_reg : data_y;

    // FSM state register.
    always_ff @(posedge clk_pix) begin
        if (rst) state_reg <= ST_IDLE;
        else     state_reg <= state_next;
    end

    // FSM next state: a sample is taken in IDLE, then one cycle each to filter and map.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (accept) state_next = ST_FILTER;
            ST_FILTER: state_next = ST_SPEED;
            ST_SPEED:  state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Sample history, newest in entry 0.
    always_ff @(posedge clk_pix) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_x_reg[i] <= '0;
                buf_y_reg[i] <= '0;
            end
        end else if (accept) begin
            for (int i = BUF_DEPTH - 1; i > 0; i--) begin
                buf_x_reg[i] <= buf_x_reg[i-1];
                buf_y_reg[i] <= buf_y_reg[i-1];
            end
            buf_x_reg[0] <= cap_x;
            buf_y_reg[0] <= cap_y;
        end
    end

    // One-deep holding slot for samples that arrive while busy; overwriting flags overflow.
    always_ff @(posedge clk_pix) begin
        if (rst) begin
            pend_valid_reg <= 1'b0;
            pend_x_reg     <= '0;
            pend_y_reg     <= '0;
            ovf_reg        <= 1'b0;
        end else begin
            ovf_reg <= 1'b0;
            if (data_update && ((state_reg != ST_IDLE) || pend_valid_reg)) begin
                pend_x_reg     <= data_x;
                pend_y_reg     <= data_y;
                pend_valid_reg <= 1'b1;
                ovf_reg        <= pend_valid_reg && (state_reg != ST_IDLE);
            end else if (accept) begin
                pend_valid_reg <= 1'b0;
            end
        end
    end

`ifdef SHIP_SMOOTH_EN
    logic signed [SAMPLE_W+1:0] sum_x, sum_y;

    // Four-sample average with arithmetic (floor) division.
    always_comb begin
        sum_x = '0;
        sum_y = '0;
        for (int i = 0; i < BUF_DEPTH; i++) begin
            sum_x = sum_x + (SAMPLE_W+2)'(buf_x_reg[i]);
            sum_y = sum_y + (SAMPLE_W+2)'(buf_y_reg[i]);
        end
        filt[0] = SAMPLE_W'(sum_x >>> 2);
        filt[1] = SAMPLE_W'(sum_y >>> 2);
    end
`else
    // Unsmoothed: newest sample straight through.
    always_comb begin
        filt[0] = buf_x_reg[0];
        filt[1] = buf_y_reg[0];
    end
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_axis
            tilt_speed #(
                .DEADZONE (DEADZONE)
            ) u_tilt (
                .avg   (avg_reg[gi]),
                .speed (spd[gi])
            );
        end
    endgenerate

    assign vel_x_next = vel_load_reg ? spd[0] : vel_x_reg;
    assign vel_y_next = vel_load_reg ? spd[1] : vel_y_reg;

    // Filter result latched in FILTER; SPEED arms a velocity load that lands one edge later.
    always_ff @(posedge clk_pix) begin
        if (rst) begin
            avg_reg[0]   <= '0;
            avg_reg[1]   <= '0;
            vel_load_reg <= 1'b0;
            vel_x_reg    <= '0;
            vel_y_reg    <= '0;
            moving_reg   <= 1'b0;
        end else begin
            if (state_reg == ST_FILTER) begin
                avg_reg[0] <= filt[0];
                avg_reg[1] <= filt[1];
            end
            vel_load_reg <= (state_reg == ST_SPEED);
            vel_x_reg    <= vel_x_next;
            vel_y_reg    <= vel_y_next;
            moving_reg   <= (vel_x_next != 3'sd0) || (vel_y_next != 3'sd0);
        end
    end

    // Signed, widened step then clamp; positive x tilt moves left, positive y tilt down.
    always_comb begin
        x_sum = $signed({2'b00, ship_x_reg}) - PW'(vel_x_reg);
        y_sum = $signed({2'b00, ship_y_reg}) + PW'(vel_y_reg);
        if (x_sum[PW-1])       ship_x_next = '0;
        else if (x_sum > X_MAX) ship_x_next = SCREEN_CORDW'(H_RES - SHIP_W);
        else                    ship_x_next = x_sum[SCREEN_CORDW-1:0];
        if (y_sum[PW-1])       ship_y_next = '0;
        else if (y_sum > Y_MAX) ship_y_next = SCREEN_CORDW'(V_RES - SHIP_H);
        else                    ship_y_next = y_sum[SCREEN_CORDW-1:0];
    end

    // Position advances once per frame using the velocity held before this edge.
    always_ff @(posedge clk_pix) begin
        if (rst) begin
            ship_x_reg <= SCREEN_CORDW'(X_INIT);
            ship_y_reg <= SCREEN_CORDW'(Y_INIT);
        end else if (frame && !hold) begin
            ship_x_reg <= ship_x_next;
            ship_y_reg <= ship_y_next;
        end
    end

    assign ship_x     = ship_x_reg;
    assign ship_y     = ship_y_reg;
    assign moving     = moving_reg;
    assign sample_ovf = ovf_reg;

endmodule

// File: tb/tb_ship_motion.sv
// Directed bench for ship_motion with a reference model and scoreboard queues.
// Follows the SHIP_SMOOTH_EN build option so expectations match either build.
`timescale 1ns/1ps
module tb_ship_motion;
    import ship_pkg::*;

    logic               clk_pix = 1'b0;
    logic               rst, data_update, frame, hold;
    logic signed [15:0] data_x, data_y;
    logic [15:0]        ship_x, ship_y;
    logic               moving, sample_ovf;

    always #5 clk_pix = ~clk_pix;

    ship_motion dut (
        .clk_pix     (clk_pix),
        .rst         (rst),
        .data_x      (data_x),
        .data_y      (data_y),
        .data_update (data_update),
        .frame       (frame),
        .hold        (hold),
        .ship_x      (ship_x),
        .ship_y      (ship_y),
        .moving      (moving),
        .sample_ovf  (sample_ovf)
    );

    typedef struct { logic [15:0] x; logic [15:0] y; } pos_t;
    typedef struct { logic signed [2:0] vx; logic signed [2:0] vy; logic mv; } vel_t;

    pos_t pos_q[$];
    vel_t vel_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_bx[4], m_by[4];
    int   m_vx, m_vy, m_px, m_py;

    task automatic tick;
        @(posedge clk_pix);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic int spd_of(input int a);
        int m, lvl;
        m = (a < 0) ? -a : a;
        if (m < 128)       lvl = 0;
        else if (m < 512)  lvl = 1;
        else if (m < 1024) lvl = 2;
        else               lvl = 3;
        return (a < 0) ? -lvl : lvl;
    endfunction

    function automatic int avg_of(input int b[4]);
`ifdef SHIP_SMOOTH_EN
        return (b[0] + b[1] + b[2] + b[3]) >>> 2;
`else
        return b[0];
`endif
    endfunction

    function automatic int clampi(input int v, input int hi);
        if (v < 0)  return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_reset;
        for (int i = 0; i < 4; i++) begin
            m_bx[i] = 0;
            m_by[i] = 0;
        end
        m_vx = 0; m_vy = 0; m_px = 300; m_py = 240;
        pos_q.delete();
        vel_q.delete();
    endtask

    // Model side of a sample: shift history, derive the expected velocity.
    task automatic model_sample(input int x, input int y);
        vel_t v;
        for (int i = 3; i > 0; i--) begin
            m_bx[i] = m_bx[i-1];
            m_by[i] = m_by[i-1];
        end
        m_bx[0] = x; m_by[0] = y;
        m_vx = spd_of(avg_of(m_bx));
        m_vy = spd_of(avg_of(m_by));
        v.vx = 3'(m_vx); v.vy = 3'(m_vy); v.mv = (m_vx != 0) || (m_vy != 0);
        vel_q.push_back(v);
    endtask

    task automatic check_vel(input string tag);
        vel_t v;
        v = vel_q.pop_front();
        chk({tag, "_vx"}, 32'($signed(dut.vel_x_reg)), 32'($signed(v.vx)));
        chk({tag, "_vy"}, 32'($signed(dut.vel_y_reg)), 32'($signed(v.vy)));
        chk({tag, "_mv"}, 32'(moving), 32'(v.mv));
    endtask

    task automatic do_reset;
        rst = 1'b1; tick; tick; rst = 1'b0;
        model_reset();
    endtask

    // One sample through the pipeline; velocity lands on the third edge after capture.
    task automatic send_sample(input int x, input int y);
        model_sample(x, y);
        data_x = 16'(x); data_y = 16'(y); data_update = 1'b1;
        tick;
        data_update = 1'b0;
        tick; tick; tick;
        check_vel("vel");
    endtask

    task automatic set_tilt(input int x, input int y);
        repeat (4) send_sample(x, y);
    endtask

    task automatic do_frame(input string tag);
        pos_t p, e;
        if (!hold) begin
            m_px = clampi(m_px - m_vx, 640 - 34);
            m_py = clampi(m_py + m_vy, 480 - 36);
        end
        e.x = 16'(m_px); e.y = 16'(m_py);
        pos_q.push_back(e);
        frame = 1'b1;
        tick;
        frame = 1'b0;
        p = pos_q.pop_front();
        chk({tag, "_x"}, 32'(ship_x), 32'(p.x));
        chk({tag, "_y"}, 32'(ship_y), 32'(p.y));
    endtask

    initial begin
        int guard;
        rst = 1'b1; data_update = 1'b0; frame = 1'b0; hold = 1'b0;
        data_x = '0; data_y = '0;

        // Reset state
        do_reset();
        chk("rst_ship_x", 32'(ship_x), 32'd300);
        chk("rst_ship_y", 32'(ship_y), 32'd240);
        chk("rst_moving", 32'(moving), 32'd0);
        chk("rst_ovf", 32'(sample_ovf), 32'd0);
        chk("rst_state", 32'(dut.state_reg), 32'(ST_IDLE));

        // Single small sample
        send_sample(400, 0);
        do_frame("s1_f1");
        do_frame("s1_f2");

        // Four medium samples
        do_reset();
        set_tilt(600, 0);
        do_frame("s4_f1");
        do_frame("s4_f2");

        // Drive x down to 1 then clamp at 0
        set_tilt(2000, 0);
        guard = 0;
        while (m_px >= 4 && guard < 300) begin
            do_frame("run_x");
            guard++;
        end
        if (m_px == 3) begin set_tilt(600, 0); do_frame("adj_x"); end
        if (m_px == 2) begin set_tilt(200, 0); do_frame("adj_x"); end
        chk("x_at_1", 32'(ship_x), 32'd1);
        set_tilt(2000, 0);
        do_frame("clamp_x");
        chk("x_clamp0", 32'(ship_x), 32'd0);
        do_frame("hold_x0");

        // Drive y to 443 then clamp at 444
        set_tilt(2000, 2000);
        guard = 0;
        while (m_py <= 440 && guard < 300) begin
            do_frame("run_y");
            guard++;
        end
        if (m_py == 441) begin set_tilt(2000, 600); do_frame("adj_y"); end
        if (m_py == 442) begin set_tilt(2000, 200); do_frame("adj_y"); end
        chk("y_at_443", 32'(ship_y), 32'd443);
        set_tilt(2000, 2000);
        do_frame("clamp_y");
        chk("y_clamp444", 32'(ship_y), 32'd444);
        do_frame("hold_y444");

        // Samples in IDLE, FILTER and SPEED: one overflow, third sample kept
        do_reset();
        data_x = -16'sd600; data_y = 16'sd200; data_update = 1'b1;
        model_sample(-600, 200);
        tick;
        chk("ovf_e0", 32'(sample_ovf), 32'd0);
        data_x = 16'sd2000; data_y = 16'sd2000;
        tick;
        chk("ovf_e1", 32'(sample_ovf), 32'd0);
        data_x = 16'sd200; data_y = -16'sd600;
        tick;
        data_update = 1'b0;
        chk("ovf_pulse", 32'(sample_ovf), 32'd1);
        tick;
        chk("ovf_clear", 32'(sample_ovf), 32'd0);
        check_vel("ovf_a");
        model_sample(200, -600);
        tick; tick; tick;
        check_vel("ovf_c");
        chk("ovf_none", 32'(sample_ovf), 32'd0);

        // Reset while in SPEED aborts the large sample
        data_x = 16'sd2000; data_y = 16'sd0; data_update = 1'b1;
        tick;
        data_update = 1'b0;
        tick;
        chk("abort_in_speed", 32'(dut.state_reg), 32'(ST_SPEED));
        rst = 1'b1;
        tick;
        rst = 1'b0;
        model_reset();
        chk("abort_vx", 32'($signed(dut.vel_x_reg)), 32'd0);
        chk("abort_x", 32'(ship_x), 32'd300);
        chk("abort_state", 32'(dut.state_reg), 32'(ST_IDLE));
        tick;
        chk("abort_vx_after", 32'($signed(dut.vel_x_reg)), 32'd0);
        chk("abort_moving", 32'(moving), 32'd0);

        // Hold freezes position while samples still update velocity
        hold = 1'b1;
        set_tilt(0, -200);
        chk("hold_vy", 32'($signed(dut.vel_y_reg)), 32'hFFFF_FFFF);
        repeat (5) do_frame("hold");
        chk("hold_y240", 32'(ship_y), 32'd240);
        chk("hold_moving", 32'(moving), 32'd1);
        hold = 1'b0;
        do_frame("release");
        chk("release_y239", 32'(ship_y), 32'd239);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
